// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: controller state encoding and default timing constants shared by RTL and bench
package cpu_clk_pkg;
  typedef enum logic [1:0] {RST_HOLD, RUN, HALT, STEP} state_t;
  localparam int DEFAULT_DIV = 20;
  localparam int RST_HOLD_CYCLES = 16;
  localparam int DIV_WIDTH = 8;
  localparam int CNT_WIDTH = 32;
endpackage

// File: rtl/clk_en_divider.sv
// clk_en_divider: period counter with boundary flag; the owner only pulses load where a reload cannot split a period
module clk_en_divider #(
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = 20
) (
  input  logic             CLK100MHZ,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             boundary
);
  logic [DIV_W-1:0] div, count;
  assign boundary = count == div - DIV_W'(1);
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      div <= DIV_W'(DEFAULT_DIV);
      count <= '0;
    end else begin
      if (load) div <= (load_div == '0) ? DIV_W'(1) : load_div;
      count <= clear ? '0 : !en ? count : boundary ? '0 : count + DIV_W'(1);
    end
  end
endmodule

// File: rtl/cpu_clk_en_ctrl.sv
// cpu_clk_en_ctrl: CPU clock-enable generator with reset sequencing, run/halt/step control and divisor handshake
module cpu_clk_en_ctrl #(
  parameter int DEFAULT_DIV = 20,
  parameter int DIV_W = 8,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK100MHZ,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             div_cfg_valid,
  output logic             div_cfg_ready,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic             cpu_ce,
  output logic             cpu_rst_n,
  output logic             halted,
  output logic [CNT_W-1:0] ce_count
);
  import cpu_clk_pkg::*;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  state_t state, state_n;
  logic [HOLD_W-1:0] hold;
  logic [DIV_W-1:0] pend;
  logic pend_valid, boundary, running, pulse, apply;
  // dropping run in RUN stops the counter on that very edge, so a coinciding boundary yields no pulse
  assign running = (state == RUN) ? run : (state == STEP);
  assign pulse = running && boundary;
  assign apply = pend_valid && (running ? boundary : (state == HALT || state == RST_HOLD));
  assign cpu_rst_n = state != RST_HOLD;
  assign halted = state == HALT;
  assign div_cfg_ready = !pend_valid;
  always_comb begin
    state_n = state;
    case (state)
      RST_HOLD: if (hold == HOLD_W'(RST_HOLD_CYCLES - 1)) state_n = run ? RUN : HALT;
      RUN:      if (!run) state_n = HALT;
      HALT:     state_n = run ? RUN : (step_req && !step_ack) ? STEP : HALT;
      STEP:     if (boundary) state_n = HALT;
      default:  state_n = RST_HOLD;
    endcase
  end
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state <= RST_HOLD;
      hold <= '0;
      pend <= '0;
      pend_valid <= 1'b0;
      cpu_ce <= 1'b0;
      step_ack <= 1'b0;
      ce_count <= '0;
    end else begin
      state <= state_n;
      if (state == RST_HOLD) hold <= hold + HOLD_W'(1);
      if (div_cfg_valid && !pend_valid) begin
        pend <= div_cfg;
        pend_valid <= 1'b1;
      end else if (apply) pend_valid <= 1'b0;
      cpu_ce <= pulse;
      step_ack <= pulse && state == STEP;
      ce_count <= ce_count + CNT_W'(pulse);
    end
  end
  clk_en_divider #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_div (
    .CLK100MHZ(CLK100MHZ),
    .reset_n(reset_n),
    .clear(!running),
    .en(running),
    .load(apply),
    .load_div(pend),
    .boundary(boundary)
  );
endmodule

// File: tb/tb_cpu_clk_en_ctrl.sv
// tb_cpu_clk_en_ctrl: directed vector table, corner sequences and random run against a cycle reference model
module tb_cpu_clk_en_ctrl;
  import cpu_clk_pkg::*;
  localparam int DW = 8;
  localparam int CW = 32;
  logic CLK100MHZ = 1'b0, reset_n = 1'b0, div_cfg_valid = 1'b0, run = 1'b0, step_req = 1'b0;
  logic [DW-1:0] div_cfg = '0;
  logic div_cfg_ready, step_ack, cpu_ce, cpu_rst_n, halted;
  logic [CW-1:0] ce_count;
  int checks = 0, fails = 0;
  always #5 CLK100MHZ = ~CLK100MHZ;
  cpu_clk_en_ctrl #(.DEFAULT_DIV(DEFAULT_DIV), .DIV_W(DW), .RST_HOLD_CYCLES(RST_HOLD_CYCLES), .CNT_W(CW)) dut (
    .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .div_cfg(div_cfg), .div_cfg_valid(div_cfg_valid),
    .div_cfg_ready(div_cfg_ready), .run(run), .step_req(step_req), .step_ack(step_ack),
    .cpu_ce(cpu_ce), .cpu_rst_n(cpu_rst_n), .halted(halted), .ce_count(ce_count)
  );
  // model: released/free-running/stepping flags, cycles elapsed in the current period, pending divisor (-1 = none)
  bit m_rel, m_free, m_step, m_ce, m_ack;
  int m_hold, m_el, m_div, m_pend;
  logic [CW-1:0] m_cnt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic take_pend();
    if (m_pend >= 0) begin
      m_div = (m_pend == 0) ? 1 : m_pend;
      m_pend = -1;
    end
  endtask
  task automatic model_edge();
    bit pulse, stepped, acc;
    pulse = 0;
    stepped = 0;
    acc = div_cfg_valid && m_pend < 0;
    if (!reset_n) begin
      m_rel = 0; m_free = 0; m_step = 0; m_ce = 0; m_ack = 0;
      m_hold = RST_HOLD_CYCLES; m_el = 0; m_div = DEFAULT_DIV; m_pend = -1; m_cnt = '0;
      return;
    end
    if (!m_rel) begin
      take_pend();
      m_hold--;
      if (m_hold == 0) begin m_rel = 1; m_free = run; end
    end else if (m_free) begin
      if (!run) begin m_free = 0; m_el = 0; end
      else begin
        m_el++;
        if (m_el == m_div) begin pulse = 1; m_el = 0; take_pend(); end
      end
    end else if (m_step) begin
      m_el++;
      if (m_el == m_div) begin pulse = 1; stepped = 1; m_step = 0; m_el = 0; take_pend(); end
    end else begin
      take_pend();
      if (run) m_free = 1;
      else if (step_req && !m_ack) m_step = 1;
    end
    m_ce = pulse;
    m_ack = stepped;
    m_cnt = m_cnt + CW'(pulse);
    if (acc) m_pend = int'(div_cfg);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK100MHZ);
      model_edge();
      #1;
      chk("cpu_ce", cpu_ce, m_ce);
      chk("step_ack", step_ack, m_ack);
      chk("cpu_rst_n", cpu_rst_n, m_rel);
      chk("halted", halted, m_rel && !m_free && !m_step);
      chk("div_cfg_ready", div_cfg_ready, m_pend < 0);
      chk("ce_count", ce_count, m_cnt);
    end
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? cpu_ce : sel == 1 ? step_ack : sel == 2 ? cpu_rst_n : div_cfg_ready;
  endfunction
  task automatic wait_on(input int sel, input string name, output int n);
    n = 0;
    do begin cyc(); n++; end while (!sig(sel) && n < 300);
    if (!sig(sel)) chk({name, "_timeout"}, 0, 1);
  endtask
  task automatic send_div(input logic [DW-1:0] v);
    div_cfg = v;
    div_cfg_valid = 1'b1;
    cyc();
    div_cfg_valid = 1'b0;
  endtask
  typedef struct {bit run; int ncyc; int pulses; bit halt_end;} vec_t;
  vec_t vt[5];
  initial begin
    int n, p, a;
    logic [CW-1:0] c0;
    vt = '{'{1, 100, 5, 0}, '{0, 10, 0, 1}, '{1, 40, 1, 0}, '{1, 20, 1, 0}, '{0, 10, 0, 1}};
    cyc(3);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_ready", div_cfg_ready, 1);
    chk("rst_ce_count", ce_count, 0);
    reset_n = 1'b1;
    run = 1'b1;
    wait_on(2, "release", n);
    chk("release_latency", n, 16);
    foreach (vt[i]) begin
      p = 0;
      run = vt[i].run;
      for (int k = 0; k < vt[i].ncyc; k++) begin cyc(); p += int'(cpu_ce); end
      chk($sformatf("vec%0d_pulses", i), p, vt[i].pulses);
      chk($sformatf("vec%0d_halted", i), halted, vt[i].halt_end);
      if (i == 0) chk("ce_count_100", ce_count, 5);
    end
    // divisor change mid-period: the 20-cycle period finishes, then 4-cycle spacing
    run = 1'b1;
    cyc(8);
    send_div(8'd4);
    chk("ready_low_pending", div_cfg_ready, 0);
    wait_on(0, "change_pulse", n);
    chk("change_pulse_latency", n, 12);
    chk("ready_after_apply", div_cfg_ready, 1);
    wait_on(0, "gap4_a", n);
    chk("gap4_a", n, 4);
    wait_on(0, "gap4_b", n);
    chk("gap4_b", n, 4);
    // three single steps from HALT
    run = 1'b0;
    cyc();
    c0 = ce_count;
    for (int s = 0; s < 3; s++) begin
      step_req = 1'b1;
      wait_on(1, "step_ack", n);
      chk("step_latency", n, 5);
      chk("step_ce", cpu_ce, 1);
      step_req = 1'b0;
      cyc();
      chk("step_halted", halted, 1);
      chk("step_no_extra_ce", cpu_ce, 0);
    end
    chk("step_ce_count", ce_count - c0, 3);
    // div 0 behaves as 1, then explicit 1; halt on a boundary cycle
    run = 1'b1;
    send_div(8'd0);
    wait_on(3, "div0_apply", n);
    p = 0;
    for (int k = 0; k < 8; k++) begin cyc(); p += int'(cpu_ce); end
    chk("div0_every_cycle", p, 8);
    send_div(8'd1);
    wait_on(3, "div1_apply", n);
    p = 0;
    for (int k = 0; k < 8; k++) begin cyc(); p += int'(cpu_ce); end
    chk("div1_every_cycle", p, 8);
    run = 1'b0;
    cyc();
    chk("halt_on_boundary_ce", cpu_ce, 0);
    chk("halt_on_boundary_halted", halted, 1);
    // run wins over step_req in HALT
    run = 1'b1;
    step_req = 1'b1;
    cyc();
    chk("run_prio_halted", halted, 0);
    a = 0;
    for (int k = 0; k < 10; k++) begin cyc(); a |= int'(step_ack); end
    chk("run_prio_no_ack", a, 0);
    run = 1'b0;
    step_req = 1'b0;
    cyc();
    // reset during STEP with a divisor pending
    send_div(8'd30);
    cyc();
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    send_div(8'd7);
    chk("pend_in_step", div_cfg_ready, 0);
    cyc(3);
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_ce", cpu_ce, 0);
    chk("mid_rst_ack", step_ack, 0);
    chk("mid_rst_cpu_rst_n", cpu_rst_n, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_ce_count", ce_count, 0);
    chk("mid_rst_ready", div_cfg_ready, 1);
    reset_n = 1'b1;
    run = 1'b1;
    wait_on(2, "re_release", n);
    chk("re_release_latency", n, 16);
    wait_on(0, "div_after_reset", n);
    chk("div_after_reset", n, 20);
    for (int i = 0; i < 3000; i++) begin
      reset_n = $urandom_range(0, 499) != 0;
      if ($urandom_range(0, 15) == 0) run = ~run;
      step_req = $urandom_range(0, 3) == 0;
      div_cfg_valid = $urandom_range(0, 7) == 0;
      div_cfg = ($urandom_range(0, 9) == 0) ? DW'(20) : DW'($urandom_range(0, 5));
      cyc();
    end
    reset_n = 1'b1;
    div_cfg_valid = 1'b0;
    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_clk_en_ctrl.md
Name: cpu_clk_en_ctrl

Overview:
Generates the CPU's single-cycle clock-enable from CLK100MHZ, replacing a free-running derived clock. The ratio is programmable at runtime, and divisor changes take effect only on period boundaries. The block sequences CPU reset release after system reset and provides run/halt/single-step control for debug and UART-loader use. It sits between the board top level and the CPU wrapper; the CPU runs on CLK100MHZ gated by cpu_ce.

Parameters:
DEFAULT_DIV, 20, divisor loaded at reset (CLK100MHZ cycles per cpu_ce pulse)
DIV_W, 8, width of divisor and period counter
RST_HOLD_CYCLES, 16, CLK100MHZ cycles cpu_rst_n is held low after reset_n releases
CNT_W, 32, width of the cpu_ce pulse counter

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
reset_n  in  1  reset, synchronous, active-low; clock CLK100MHZ
div_cfg  in  DIV_W  requested divisor
div_cfg_valid  in  1  divisor request valid
div_cfg_ready  out  1  divisor request can be accepted
run  in  1  level: 1 = free-run, 0 = halt
step_req  in  1  single-step request, honoured only in HALT
step_ack  out  1  one-cycle pulse, coincident with the stepped cpu_ce
cpu_ce  out  1  CPU clock enable, one-cycle pulse
cpu_rst_n  out  1  CPU reset, active-low, synchronous to CLK100MHZ
halted  out  1  1 when in HALT state
ce_count  out  CNT_W  number of cpu_ce pulses since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset_n=0 at an edge): state=RST_HOLD, hold counter=0, period count=0, div=DEFAULT_DIV, no pending config. Outputs: cpu_ce=0, cpu_rst_n=0, step_ack=0, halted=0, ce_count=0, div_cfg_ready=1.
- Reset mid-operation behaves identically. Any in-flight step or pending divisor is discarded.
- Effective divisor: a div_cfg value of 0 is treated as 1. With div=1, cpu_ce is high every cycle in RUN.
- States:
  - RST_HOLD: hold counter increments every cycle. Once RST_HOLD_CYCLES cycles have elapsed, cpu_rst_n goes to 1 at the next edge. State then goes to RUN if run=1, else HALT. Period count is cleared.
  - RUN: period count runs 0..div-1 and wraps. cpu_ce is registered and high exactly in the cycle after count==div-1, so pulses are spaced exactly div cycles apart. The first pulse occurs div cycles after entering RUN. If run is sampled 0: go to HALT at the next edge, clear count, emit no pulse, even if the boundary coincides.
  - HALT: halted=1; count held at 0; cpu_ce=0. If run=1, go to RUN (run has priority over step_req). Else if step_req=1 and step_ack=0, go to STEP.
  - STEP: count runs as in RUN. At the boundary, emit one cpu_ce and one step_ack in the same cycle, then return to HALT. run is ignored until the step completes. step_req must drop before another step is taken, because the next step needs step_req=1 while step_ack=0.
- Divisor handshake:
  - Transfer occurs on div_cfg_valid && div_cfg_ready. The value is latched as pending and div_cfg_ready drops to 0.
  - In RUN/STEP, the pending value is applied at the edge where count wraps: count restarts at 0 under the new divisor, and the pulse for the completing period is still issued.
  - In HALT or RST_HOLD, the pending value is applied at the next edge.
  - div_cfg_ready returns to 1 in the cycle after the value is applied.
- ce_count increments on every cycle where cpu_ce=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_clk_pkg: state enum (RST_HOLD, RUN, HALT, STEP) and the DEFAULT_DIV/RST_HOLD_CYCLES constants, so the top level and testbench agree.
- One natural sub-module, clk_en_divider: period counter with a safe-reload input and boundary output. The FSM, handshakes and ce_count stay in the parent.

Test Plan:
- Reset then run=1, default params → cpu_rst_n rises 16 cycles after reset release; pulses every 20 cycles; ce_count=5 after 100 cycles of RUN.
- RUN, count=7, div_cfg=4 accepted → current 20-cycle period completes with a pulse; subsequent pulses every 4 cycles; div_cfg_ready low until applied.
- run=0, then three step_req pulses (each held until step_ack, then dropped) → exactly 3 cpu_ce pulses, each with step_ack; ce_count increments by 3; halted=1 between steps.
- div_cfg=0 then div_cfg=1 in RUN → cpu_ce high every cycle; run=0 on a boundary cycle → no pulse, halted=1 next cycle.
- Assert reset_n=0 during STEP with a pending divisor → all outputs return to reset values; after the hold, divisor is 20 (pending discarded).
- run=1 and step_req=1 together in HALT → enters RUN, no step_ack.
